// File: rtl/pipeline_pkg.sv
// Shared fetch-stage definitions: default PC vectors, sequential step and
// the RUN/HALT fetch state.
package pipeline_pkg;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;
    localparam int unsigned DEF_STEP      = 4;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: owns PC and EPC, resolves the next PC
// from exception / redirect / eret / sequential sources, and gates fetch on HALT.
module pc_gen
    import pipeline_pkg::*;
#(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_VEC = WIDTH'(DEF_RESET_VEC),
    parameter logic [WIDTH-1:0]  EXC_VEC   = WIDTH'(DEF_EXC_VEC),
    parameter int unsigned       STEP      = DEF_STEP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_f,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             exc_valid,
    input  logic [WIDTH-1:0] exc_pc,
    input  logic             eret,
    input  logic             halt_req,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] epc,
    output logic             misalign
);

    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] epc_q;
    logic [WIDTH-1:0] epc_next;
    pc_state_e        state_q;
    pc_state_e        state_next;
    logic             misalign_q;
    logic             misalign_next;
    logic             fetch_valid_q;
    logic             redirect_misaligned;

    assign pc_plus             = pc_q + STEP_W;
    assign redirect_misaligned = redirect_valid && ((redirect_pc & ALIGN_MASK) != '0);

    // Next-PC priority mux; reset is applied in the registers below.
    // A halt request taken this cycle also holds the PC so the halted
    // address is the one that was being fetched when the request arrived.
    always_comb begin
        pc_next       = pc_q;
        epc_next      = epc_q;
        state_next    = state_q;
        misalign_next = 1'b0;
        if (exc_valid) begin
            pc_next    = EXC_VEC;
            epc_next   = exc_pc;
            state_next = RUN;
        end else if (state_q == HALT) begin
            pc_next = pc_q;
        end else if (redirect_misaligned) begin
            pc_next       = EXC_VEC;
            epc_next      = redirect_pc;
            misalign_next = 1'b1;
        end else if (eret) begin
            pc_next = epc_q;
        end else if (redirect_valid) begin
            pc_next = redirect_pc;
        end else if (halt_req) begin
            state_next = HALT;
        end else if (!stall_f) begin
            pc_next = pc_plus;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= pc_next;
        end
    end

    // fetch_valid is low for the first cycle out of reset and for every HALT cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            epc_q         <= '0;
            misalign_q    <= 1'b0;
            fetch_valid_q <= 1'b0;
        end else begin
            state_q       <= state_next;
            epc_q         <= epc_next;
            misalign_q    <= misalign_next;
            fetch_valid_q <= (state_next == RUN);
        end
    end

    assign pc          = pc_q;
    assign epc         = epc_q;
    assign misalign    = misalign_q;
    assign fetch_valid = fetch_valid_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a 32-bit instance driven by directed and random
// stimulus, and an 8-bit instance that free-runs from reset to exercise wrap.
module tb_pc_gen;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc_plus;
        logic [31:0] epc;
        logic        fv;
        logic        mis;
    } exp_t;

    typedef struct {
        logic [7:0] pc;
        logic [7:0] pc_plus;
        logic       fv;
    } sexp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_f = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        exc_valid = 1'b0;
    logic [31:0] exc_pc = '0;
    logic        eret = 1'b0;
    logic        halt_req = 1'b0;

    logic [31:0] pc, pc_plus, epc;
    logic        fetch_valid, misalign;
    logic [7:0]  s_pc, s_pc_plus, s_epc;
    logic        s_fv, s_mis;

    exp_t  q[$];
    sexp_t sq[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    logic [31:0] m_pc = '0;
    logic [31:0] m_epc = '0;
    bit          m_halt = 1'b0;
    int          s_model_pc = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk(clk), .reset(reset), .stall_f(stall_f),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .exc_valid(exc_valid), .exc_pc(exc_pc), .eret(eret), .halt_req(halt_req),
        .pc(pc), .pc_plus(pc_plus), .fetch_valid(fetch_valid), .epc(epc), .misalign(misalign)
    );

    pc_gen #(.WIDTH(8), .RESET_VEC(8'hF8), .EXC_VEC(8'h80), .STEP(4)) dut8 (
        .clk(clk), .reset(reset), .stall_f(1'b0),
        .redirect_valid(1'b0), .redirect_pc(8'h00),
        .exc_valid(1'b0), .exc_pc(8'h00), .eret(1'b0), .halt_req(1'b0),
        .pc(s_pc), .pc_plus(s_pc_plus), .fetch_valid(s_fv), .epc(s_epc), .misalign(s_mis)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Apply one cycle of stimulus and queue what the outputs must show after the edge.
    task automatic drive(input bit rst, input bit st, input bit rv, input logic [31:0] rpc,
                         input bit ex, input logic [31:0] xpc, input bit er, input bit hr);
        exp_t  e;
        sexp_t s;
        bit    mis;
        @(negedge clk);
        reset = rst; stall_f = st; redirect_valid = rv; redirect_pc = rpc;
        exc_valid = ex; exc_pc = xpc; eret = er; halt_req = hr;
        mis = 1'b0;
        if (rst) begin
            m_pc = 32'h3000; m_epc = 0; m_halt = 0;
        end else if (ex) begin
            m_pc = 32'h4180; m_epc = xpc; m_halt = 0;
        end else if (m_halt) begin
            // halted: only reset or an exception can move the PC
        end else if (rv && (rpc % 4) != 0) begin
            m_pc = 32'h4180; m_epc = rpc; mis = 1'b1;
        end else if (er) begin
            m_pc = m_epc;
        end else if (rv) begin
            m_pc = rpc;
        end else if (hr) begin
            m_halt = 1'b1;
        end else if (!st) begin
            m_pc = m_pc + 32'd4;
        end
        e.pc = m_pc; e.pc_plus = m_pc + 32'd4; e.epc = m_epc;
        e.fv = rst ? 1'b0 : !m_halt;
        e.mis = mis;
        q.push_back(e);
        s_model_pc = rst ? 'hF8 : (s_model_pc + 4) % 256;
        s.pc = 8'(s_model_pc); s.pc_plus = 8'((s_model_pc + 4) % 256); s.fv = !rst;
        sq.push_back(s);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are valid every cycle, so pop one expectation per edge.
    initial begin
        exp_t  e;
        sexp_t s;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc", pc, e.pc);
                chk("pc_plus", pc_plus, e.pc_plus);
                chk("epc", epc, e.epc);
                chk("fetch_valid", 32'(fetch_valid), 32'(e.fv));
                chk("misalign", 32'(misalign), 32'(e.mis));
            end
            if (sq.size() > 0) begin
                s = sq.pop_front();
                chk("pc8", 32'(s_pc), 32'(s.pc));
                chk("pc_plus8", 32'(s_pc_plus), 32'(s.pc_plus));
                chk("fetch_valid8", 32'(s_fv), 32'(s.fv));
                chk("epc8", 32'(s_epc), 32'h0);
                chk("misalign8", 32'(s_mis), 32'h0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          rst, st, rv, ex, er, hr;
        logic [31:0] rpc, xpc;

        // reset then sequential run; 8-bit instance wraps F8, FC, 00, 04
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // stall two cycles at 0x3008, redirect in the second
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 32'h3100, 0, 0, 0, 0);
        // exception together with eret, then lone eret
        drive(0, 0, 0, 0, 1, 32'h3010, 1, 0);
        idle(1);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        // misaligned redirect traps and pulses misalign once
        drive(0, 0, 1, 32'h3102, 0, 0, 0, 0);
        idle(2);
        // halt, ignored redirect/eret, exception resumes
        drive(0, 0, 1, 32'h3020, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 1, 32'h3200, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 1, 32'h3203, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 32'h3040, 0, 0);
        idle(1);
        // reset wins over exception, mid-HALT and mid-stall
        drive(1, 1, 0, 0, 1, 32'h3050, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        // 32-bit wrap through zero
        drive(0, 0, 1, 32'hFFFF_FFF8, 0, 0, 0, 0);
        idle(3);

        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            st  = ($urandom_range(0, 99) < 20);
            rv  = ($urandom_range(0, 99) < 18);
            ex  = ($urandom_range(0, 99) < 6);
            er  = ($urandom_range(0, 99) < 6);
            hr  = ($urandom_range(0, 99) < 5);
            rpc = 32'h3000 + ($urandom_range(0, 255) << 2);
            if ($urandom_range(0, 3) == 0) rpc = rpc | 32'($urandom_range(1, 3));
            xpc = 32'h3000 + ($urandom_range(0, 255) << 2);
            drive(rst, st, rv, rpc, ex, xpc, er, hr);
        end
        idle(1);

        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (q.size() != 0 || sq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d/%0d pending, expected 0/0", q.size(), sq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
